// File: rtl/math_pkg.sv
// Shared arithmetic constants and the pipeline register layout for the
// 64-bit pipelined subtractor.
package math_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  // Contents of the first pipeline stage: the finished low half plus the
  // untouched high operands that the second stage still has to subtract.
  typedef struct packed {
    logic [HALF_W-1:0] diff_lo;
    logic              borrow_lo;
    logic [HALF_W-1:0] op1_hi;
    logic [HALF_W-1:0] op2_hi;
  } stage1_t;

endpackage

// File: rtl/pipelined_subtractor_64b_if.sv
// Operand/result handshake bundle of the 64-bit pipelined subtractor.
// The master side offers operations and consumes results; the slave side is
// the subtractor itself.
interface pipelined_subtractor_64b_if;
  import math_pkg::*;

  logic [DATA_W-1:0] operand1_i;
  logic [DATA_W-1:0] operand2_i;
  logic              borrow_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] diff_o;
  logic              borrow_o;
  logic              overflow_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    output operand1_i, operand2_i, borrow_i, valid_i, ready_i,
    input  ready_o, diff_o, borrow_o, overflow_o, valid_o
  );

  modport slave (
    input  operand1_i, operand2_i, borrow_i, valid_i, ready_i,
    output ready_o, diff_o, borrow_o, overflow_o, valid_o
  );

endinterface

// File: rtl/subtractor_32b.sv
// Combinational 32-bit subtractor with borrow chaining: computes
// minuend - subtrahend - borrow and reports the unsigned borrow out.
module subtractor_32b
  import math_pkg::*;
(
  input  logic [HALF_W-1:0] minuend,
  input  logic [HALF_W-1:0] subtrahend,
  input  logic              borrow,
  output logic [HALF_W-1:0] diff,
  output logic              borrow_next
);

  logic [HALF_W:0] wide_diff;

  // One extra bit catches the wrap-around, which is exactly the borrow out.
  assign wide_diff   = {1'b0, minuend} - {1'b0, subtrahend} - {{HALF_W{1'b0}}, borrow};
  assign diff        = wide_diff[HALF_W-1:0];
  assign borrow_next = wide_diff[HALF_W];

endmodule

// File: rtl/pipelined_subtractor_64b.sv
// Two-stage 64-bit subtractor with valid/ready handshakes on both sides.
// Stage 1 subtracts the low halves, stage 2 finishes the high halves using the
// registered low borrow and produces the registered result.
module pipelined_subtractor_64b
  import math_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  pipelined_subtractor_64b_if.slave   bus
);

  stage1_t           s1_data;
  logic              s1_valid;

  logic [DATA_W-1:0] s2_diff;
  logic              s2_borrow;
  logic              s2_overflow;
  logic              s2_valid;

  logic [HALF_W-1:0] lo_diff;
  logic              lo_borrow;
  logic [HALF_W-1:0] hi_diff;
  logic              hi_borrow;

  logic              s2_load;
  logic              s1_advance;
  logic              ready;
  logic              hi_overflow;

  subtractor_32b u_sub_lo (
    .minuend     (bus.operand1_i[HALF_W-1:0]),
    .subtrahend  (bus.operand2_i[HALF_W-1:0]),
    .borrow      (bus.borrow_i),
    .diff        (lo_diff),
    .borrow_next (lo_borrow)
  );

  subtractor_32b u_sub_hi (
    .minuend     (s1_data.op1_hi),
    .subtrahend  (s1_data.op2_hi),
    .borrow      (s1_data.borrow_lo),
    .diff        (hi_diff),
    .borrow_next (hi_borrow)
  );

  // Flow control: stage 2 refills when empty or drained this cycle, stage 1
  // only moves when stage 2 takes its contents. ready depends on ready_i and
  // state only, never on valid_i.
  assign s2_load    = !s2_valid || bus.ready_i;
  assign s1_advance = s1_valid && s2_load;
  assign ready      = !s1_valid || s1_advance;

  // Signed overflow: operands of opposite sign and a result whose sign
  // differs from the minuend.
  assign hi_overflow = (s1_data.op1_hi[HALF_W-1] != s1_data.op2_hi[HALF_W-1]) &&
                       (hi_diff[HALF_W-1] != s1_data.op1_hi[HALF_W-1]);

  // Stage 1 captures a new low-half result whenever it can move on, and
  // simply empties when nothing new is offered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (ready) begin
      s1_valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1_data.diff_lo   <= lo_diff;
        s1_data.borrow_lo <= lo_borrow;
        s1_data.op1_hi    <= bus.operand1_i[DATA_W-1:HALF_W];
        s1_data.op2_hi    <= bus.operand2_i[DATA_W-1:HALF_W];
      end
    end
  end

  // Stage 2 holds the final result until downstream takes it; data only
  // changes when a real operation moves in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid    <= 1'b0;
      s2_diff     <= '0;
      s2_borrow   <= 1'b0;
      s2_overflow <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_diff     <= {hi_diff, s1_data.diff_lo};
        s2_borrow   <= hi_borrow;
        s2_overflow <= hi_overflow;
      end
    end
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = s2_valid;
  assign bus.diff_o     = s2_diff;
  assign bus.borrow_o   = s2_borrow;
  assign bus.overflow_o = s2_overflow;

endmodule

// File: doc/pipelined_subtractor_64b.md
PIPELINED_SUBTRACTOR_64B -- requirements
Module: pipelined_subtractor_64b

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 64 bits, split into two 32-bit halves.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 operand1_i  input  64  minuend.
REQ-005 operand2_i  input  64  subtrahend.
REQ-006 borrow_i  input  1  incoming borrow; result is operand1_i - operand2_i - borrow_i.
REQ-007 valid_i  input  1  upstream offers an operation this cycle.
REQ-008 ready_o  output  1  block can accept an operation this cycle.
REQ-009 diff_o  output  64  difference, modulo 2^64.
REQ-010 borrow_o  output  1  unsigned borrow out: 1 when operand1 < operand2 + borrow_i.
REQ-011 overflow_o  output  1  two's-complement signed overflow of the subtraction.
REQ-012 valid_o  output  1  diff_o/borrow_o/overflow_o hold a result.
REQ-013 ready_i  input  1  downstream accepts the result this cycle.

Function
REQ-014 An operation SHALL be accepted on a rising edge where valid_i and ready_o are both 1; a result SHALL be consumed on an edge where valid_o and ready_i are both 1.
REQ-015 Stage 1 SHALL compute the low 32-bit difference and low borrow, and register them with operand1_i[63:32], operand2_i[63:32] and a stage-1 valid bit.
REQ-016 Stage 2 SHALL compute the high 32-bit difference from the registered high operands and the registered low borrow, then register diff_o, borrow_o, overflow_o and valid_o.
REQ-017 Latency SHALL be exactly 2 cycles from acceptance to valid_o when ready_i stays 1.
REQ-018 Throughput SHALL be one operation per cycle when ready_i stays 1.
REQ-019 Stage 2 SHALL load when it is empty or its result is consumed in the same cycle.
REQ-020 Stage 1 SHALL advance into stage 2 only when stage 2 loads; otherwise it SHALL hold its contents.
REQ-021 ready_o SHALL be 1 when stage 1 is empty or stage 1 advances in the same cycle. ready_o is combinational from ready_i, with no combinational path from valid_i.
REQ-022 When ready_i=0, valid_o=1 and stage 1 is full, ready_o SHALL be 0 and all registered data SHALL hold unchanged.
REQ-023 Simultaneous accept and consume at full occupancy SHALL neither lose nor duplicate any operation.
REQ-024 Output data SHALL be stable while valid_o=1 and ready_i=0.
REQ-025 overflow_o SHALL be 1 iff operand1[63] != operand2[63] and diff[63] != operand1[63].
REQ-026 Output data values when valid_o=0 are don't-care; verification SHALL NOT check them.

Reset
REQ-027 While rst_i=1, both stage valid bits, valid_o, diff_o, borrow_o and overflow_o SHALL be 0, asynchronously.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear on the output after deassertion.
REQ-029 ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Structure
REQ-030 The widths (64, 32) SHALL be defined as constants in the shared math package, math_pkg.
REQ-031 The half-width arithmetic SHALL be one combinational sub-module, subtractor_32b (operands, borrow in -> difference, borrow out), instantiated twice.
REQ-032 No other sub-modules SHALL be used.

Verification
REQ-033 Operands 5, 3, borrow_i=0, ready_i=1 -> diff_o=2, borrow_o=0, overflow_o=0, valid_o exactly 2 cycles after acceptance.
REQ-034 Operands 0, 1, borrow_i=0 -> diff_o=0xFFFF_FFFF_FFFF_FFFF, borrow_o=1; operands 0x1_0000_0000, 1 -> diff_o=0xFFFF_FFFF (cross-half borrow).
REQ-035 Operands 0x8000_0000_0000_0000, 1 -> diff_o=0x7FFF_FFFF_FFFF_FFFF, overflow_o=1, borrow_o=0.
REQ-036 Back-to-back stream of 8 operations, ready_i held 0 for 3 cycles mid-stream -> ready_o falls when both stages are full, all 8 results appear in order, with none lost or duplicated.
REQ-037 Assert rst_i with both stages full -> valid_o=0 immediately; no stale result after release; ready_o=1 on the next cycle.
REQ-038 Randomized 10k operations with random valid_i/ready_i -> every result matches a reference model of the 65-bit subtraction.
